// File: rtl/rv_cpu_run_logger.sv
// Run controller for the RV CPU: programmable reset sequencer plus a timestamped
// change-capture FIFO on cpu_out. Define RV_LOG_STOP_ON_FULL_EN to freeze the CPU on the first dropped capture.
module rv_cpu_run_logger #(
    parameter int OUT_W       = 10,
    parameter int DEPTH       = 16,
    parameter int TS_W        = 16,
    parameter int PRE_CYCLES  = 5,
    parameter int HOLD_CYCLES = 25
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [OUT_W-1:0]          cpu_out,
    output logic                      cpu_reset,
    input  logic                      rd_en,
    output logic [TS_W+OUT_W-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [2:0]                state
);
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int DW      = TS_W + OUT_W;
    localparam int SEQ_MAX = (PRE_CYCLES > HOLD_CYCLES) ? PRE_CYCLES : HOLD_CYCLES;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic [OUT_W-1:0]    prev_q, prev_d;
    logic                cpu_reset_q;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;
    logic [DW-1:0]       rd_data_q;
    logic                rd_valid_q;
    logic                overflow_q;
    logic [DW-1:0]       mem_q [DEPTH];

    logic in_run, wr_req, wr_ok, rd_acc, drop;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        seq_d   = seq_q;
        ts_d    = ts_q;
        prev_d  = prev_q;

        in_run = (state_q == S_RUN);
        // ts_q is only zero on the first RUN cycle, so it doubles as the forced-capture marker.
        wr_req = in_run && ((ts_q == '0) || (cpu_out != prev_q));
        rd_acc = rd_en && (count_q != '0);
        wr_ok  = wr_req && ((count_q != CW'(DEPTH)) || rd_acc);
        drop   = wr_req && !wr_ok;

        if (in_run) begin
            prev_d = cpu_out;
            if (ts_q != '1) ts_d = ts_q + TS_W'(1);
        end else begin
            ts_d = '0;
        end

        case (state_q)
            S_PRE: begin
                if (seq_q == SEQ_W'(PRE_CYCLES - 1)) begin
                    state_d = S_HOLD;
                    seq_d   = '0;
                end else begin
                    seq_d = seq_q + SEQ_W'(1);
                end
            end
            S_HOLD: begin
                if (seq_q == SEQ_W'(HOLD_CYCLES - 1)) begin
                    state_d = S_RUN;
                    seq_d   = '0;
                end else begin
                    seq_d = seq_q + SEQ_W'(1);
                end
            end
            S_RUN: begin
`ifdef RV_LOG_STOP_ON_FULL_EN
                if (drop) state_d = S_DONE;
`endif
            end
            S_IDLE, S_DONE: ;
            default: state_d = S_IDLE;
        endcase

        // Start relaunches from any state; the FIFO and overflow flag are left alone.
        if (start) begin
            state_d = S_PRE;
            seq_d   = '0;
            ts_d    = '0;
            prev_d  = '0;
        end

        case ({wr_ok, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            seq_q       <= '0;
            ts_q        <= '0;
            prev_q      <= '0;
            cpu_reset_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            ts_q        <= ts_d;
            prev_q      <= prev_d;
            cpu_reset_q <= (state_d == S_HOLD) || (state_d == S_DONE);
            count_q     <= count_d;
            rd_valid_q  <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem_q[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + AW'(1);
            end
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (drop) overflow_q <= 1'b1;
        end
    end

    // NOTE: storage is not reset; occupancy is tracked by count_q, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (reset && wr_ok) mem_q[wr_ptr_q] <= {ts_q, cpu_out};
    end

    assign cpu_reset = cpu_reset_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign overflow  = overflow_q;
    assign state     = state_q;
endmodule
